// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, writeback data mux,
// EX-stage forwarding select generation and load-use stall detection.
// Optional feature macro: WB_RETIRE_CNT_EN (retired-instruction counter).
// When the macro is undefined, retire_count is tied to zero.
module mem_wb_writeback #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_mem_valid,
  input  logic [RADDR_W-1:0] ex_mem_rd,
  input  logic               ex_mem_regwrite,
  input  logic               ex_mem_memtoreg,
  input  logic [XLEN-1:0]    ex_mem_alu,
  input  logic [XLEN-1:0]    mem_read_data,
  input  logic               wb_stall,
  input  logic               wb_flush,
  input  logic [RADDR_W-1:0] id_ex_rs1,
  input  logic [RADDR_W-1:0] id_ex_rs2,
  input  logic               id_ex_memread,
  input  logic [RADDR_W-1:0] id_ex_rd,
  input  logic [RADDR_W-1:0] if_id_rs1,
  input  logic [RADDR_W-1:0] if_id_rs2,
  output logic [RADDR_W-1:0] mem_wb_rd,
  output logic               mem_wb_regwrite,
  output logic [XLEN-1:0]    mem_wb_mux,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   retire_count
);

  // Forward select codes, ordered as the EX-stage mux inputs.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic               r_wb_valid;
  logic [RADDR_W-1:0] r_rd;
  logic               r_regwrite;
  logic               r_memtoreg;
  logic [XLEN-1:0]    r_alu;
  logic [XLEN-1:0]    r_load;

  logic               w_hold;
  logic               w_wb_write;

  // Select the youngest producer of a source register. A load sitting in
  // EX_MEM has no data yet, so it only forwards once it reaches MEM_WB.
  function automatic logic [1:0] fwd_sel(
    input logic [RADDR_W-1:0] rs,
    input logic               em_valid,
    input logic               em_regwrite,
    input logic               em_memtoreg,
    input logic [RADDR_W-1:0] em_rd,
    input logic               wb_write,
    input logic [RADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    if (em_valid && em_regwrite && !em_memtoreg &&
        (em_rd != {RADDR_W{1'b0}}) && (em_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_write && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Flush overrides stall, so a register hold only happens without flush.
  assign w_hold = wb_stall & ~wb_flush;

  // MEM/WB register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_rd       <= {RADDR_W{1'b0}};
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alu      <= {XLEN{1'b0}};
      r_load     <= {XLEN{1'b0}};
    end else if (wb_flush) begin
      r_wb_valid <= 1'b0;
      r_rd       <= {RADDR_W{1'b0}};
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alu      <= {XLEN{1'b0}};
      r_load     <= {XLEN{1'b0}};
    end else if (wb_stall) begin
      r_wb_valid <= r_wb_valid;
      r_rd       <= r_rd;
      r_regwrite <= r_regwrite;
      r_memtoreg <= r_memtoreg;
      r_alu      <= r_alu;
      r_load     <= r_load;
    end else begin
      r_wb_valid <= ex_mem_valid;
      r_rd       <= ex_mem_rd;
      r_regwrite <= ex_mem_regwrite & ex_mem_valid;
      r_memtoreg <= ex_mem_memtoreg;
      r_alu      <= ex_mem_alu;
      r_load     <= mem_read_data;
    end
  end

  // Register-file write enable; x0 is hardwired so writes to it are dropped.
  assign w_wb_write      = r_regwrite & r_wb_valid & (r_rd != {RADDR_W{1'b0}});
  assign mem_wb_regwrite = w_wb_write;
  assign mem_wb_rd       = r_rd;

  // Writeback data mux from the registered fields.
  always_comb begin
    mem_wb_mux = r_alu;
    if (r_memtoreg) begin
      mem_wb_mux = r_load;
    end else begin
      mem_wb_mux = r_alu;
    end
  end

  // Forwarding selects and load-use hazard detection.
  always_comb begin
    forward_a      = FWD_RF;
    forward_b      = FWD_RF;
    load_use_stall = 1'b0;
    forward_a = fwd_sel(id_ex_rs1, ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg,
                        ex_mem_rd, w_wb_write, r_rd);
    forward_b = fwd_sel(id_ex_rs2, ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg,
                        ex_mem_rd, w_wb_write, r_rd);
    if (id_ex_memread && (id_ex_rd != {RADDR_W{1'b0}}) &&
        ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2))) begin
      load_use_stall = 1'b1;
    end else begin
      load_use_stall = 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_count;

  // Count each valid instruction leaving writeback; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_count <= {CNT_W{1'b0}};
    end else if (r_wb_valid && !w_hold) begin
      r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  assign retire_count = r_retire_count;
`else
  assign retire_count = {CNT_W{1'b0}};
`endif

endmodule
